// File: rtl/shift_pkg.sv
// Shared types and constants for the 12-bit serial link.
// Used by both the transmit (shift_out) and receive ends.
package shift_pkg;

    localparam int unsigned SHIFT_DEFAULT_WIDTH = 12;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Number of serial bits in one frame; the parity bit adds one.
    function automatic int unsigned shift_nbits(input int unsigned width, input bit parity_en);
        return parity_en ? width + 1 : width;
    endfunction

endpackage

// File: rtl/shift_out_if.sv
// Parallel load/ready handshake plus the serial-side outputs of shift_out.
// master = word producer / line observer, slave = transmitter.
interface shift_out_if
    import shift_pkg::*;
#(
    parameter int unsigned WIDTH = SHIFT_DEFAULT_WIDTH
) ();

    logic             ena;
    logic             load;
    logic [WIDTH-1:0] data_in;
    logic             ready;
    logic             data_out;
    logic             frame;
    logic             done;

    modport master (output ena, load, data_in, input ready, data_out, frame, done);
    modport slave  (input ena, load, data_in, output ready, data_out, frame, done);

endinterface

// File: rtl/shift_bit_counter.sv
// Enable-gated up-counter with synchronous clear and a terminal-count flag.
// Shared by the transmit and receive ends of the serial link.
module shift_bit_counter #(
    parameter int unsigned CW   = 4,
    parameter int unsigned LAST = 11
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    localparam logic [CW-1:0] LAST_C = CW'(LAST);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == LAST_C);

endmodule

// File: rtl/shift_out.sv
// Parallel-to-serial transmitter, MSB first, one bit per ena strobe.
// Define SHIFT_OUT_PARITY_EN to append an even-parity bit after the data bits.
module shift_out
    import shift_pkg::*;
#(
    parameter int unsigned WIDTH = SHIFT_DEFAULT_WIDTH
) (
    input  logic      clk,
    input  logic      rst,
    shift_out_if.slave bus
);

`ifdef SHIFT_OUT_PARITY_EN
    localparam bit PARITY_EN = 1'b1;
`else
    localparam bit PARITY_EN = 1'b0;
`endif

    localparam int unsigned NBITS = shift_nbits(WIDTH, PARITY_EN);
    localparam int unsigned CW    = $clog2(WIDTH + 2);

    state_t           state_q;
    state_t           state_d;
    logic [NBITS-1:0] sr_q;
    logic [NBITS-1:0] sr_d;
    logic [NBITS-1:0] load_word;
    logic             cnt_clr;
    logic             cnt_en;
    logic             last_bit;

    // Parity rides at the bottom of the shift register so it leaves last.
`ifdef SHIFT_OUT_PARITY_EN
    assign load_word = {bus.data_in, ^bus.data_in};
`else
    assign load_word = bus.data_in;
`endif

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        cnt_clr = 1'b0;
        cnt_en  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.load) begin
                    sr_d    = load_word;
                    cnt_clr = 1'b1;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (bus.ena) begin
                    sr_d   = {sr_q[NBITS-2:0], 1'b0};
                    cnt_en = 1'b1;
                    if (last_bit) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            sr_q    <= '0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
        end
    end

    shift_bit_counter #(
        .CW   (CW),
        .LAST (NBITS - 1)
    ) u_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr_i (cnt_clr),
        .en_i  (cnt_en),
        .tc_o  (last_bit)
    );

    assign bus.ready    = (state_q == ST_IDLE);
    assign bus.frame    = (state_q == ST_SHIFT);
    assign bus.done     = (state_q == ST_DONE);
    assign bus.data_out = bus.frame & sr_q[NBITS-1];

endmodule

// File: tb/tb_shift_out.sv
// Scoreboard bench for shift_out: stimulus pushes expected status and bits,
// a negedge monitor pops and compares against the live outputs.
module tb_shift_out;

    localparam int unsigned WIDTH = 12;
`ifdef SHIFT_OUT_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif
    localparam int NB = WIDTH + (PAR ? 1 : 0);

    logic clk = 1'b1;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    shift_out_if #(.WIDTH(WIDTH)) bus ();

    shift_out #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int   checks = 0;
    int   errors = 0;
    bit   stop   = 1'b0;

    // Reference model: bits still to send, and a pending done cycle.
    int       rem   = 0;
    bit       dflag = 1'b0;
    bit       exp_q[$];
    logic [2:0] st_q[$];

    task automatic push_status();
        st_q.push_back({(rem == 0 && !dflag), (rem > 0), dflag});
    endtask

    task automatic model_edge(input logic e, input logic l, input logic [WIDTH-1:0] d);
        if (dflag) begin
            dflag = 1'b0;
        end else if (rem > 0) begin
            if (e) begin
                rem--;
                if (rem == 0) dflag = 1'b1;
            end
        end else if (l) begin
            rem = NB;
            for (int i = WIDTH - 1; i >= 0; i--) exp_q.push_back(d[i]);
            if (PAR) exp_q.push_back(^d);
        end
    endtask

    task automatic step(input logic e, input logic l, input logic [WIDTH-1:0] d);
        push_status();
        bus.ena     = e;
        bus.load    = l;
        bus.data_in = d;
        @(posedge clk);
        model_edge(e, l, d);
        #1;
    endtask

    task automatic do_reset(input int n);
        rst   = 1'b0;
        rem   = 0;
        dflag = 1'b0;
        exp_q.delete();
        bus.ena  = 1'b0;
        bus.load = 1'b0;
        repeat (n) begin
            push_status();
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
    endtask

    // Monitor
    initial begin
        logic [2:0] exp_st;
        bit         exp_b;
        forever begin
            @(negedge clk);
            if (stop) break;
            checks++;
            if (st_q.size() == 0) begin
                errors++;
                $display("FAIL status_underflow t=%0t", $time);
            end else begin
                exp_st = st_q.pop_front();
                if ({bus.ready, bus.frame, bus.done} !== exp_st) begin
                    errors++;
                    $display("FAIL status t=%0t rdy/frm/done got=%b exp=%b",
                             $time, {bus.ready, bus.frame, bus.done}, exp_st);
                end
            end
            if (bus.frame && bus.ena) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL bit_underflow t=%0t got=%b", $time, bus.data_out);
                end else begin
                    exp_b = exp_q.pop_front();
                    if (bus.data_out !== exp_b) begin
                        errors++;
                        $display("FAIL serial_bit t=%0t got=%b exp=%b", $time, bus.data_out, exp_b);
                    end
                end
            end else if (!bus.frame) begin
                checks++;
                if (bus.data_out !== 1'b0) begin
                    errors++;
                    $display("FAIL idle_data t=%0t got=%b exp=0", $time, bus.data_out);
                end
            end
        end
    end

    // Stimulus
    initial begin
        int budget;
        bus.ena     = 1'b0;
        bus.load    = 1'b0;
        bus.data_in = '0;

        do_reset(3);
        step(1'b0, 1'b0, '0);

        // Continuous ena, 12'hA5C
        step(1'b1, 1'b1, 12'hA5C);
        repeat (NB + 2) step(1'b1, 1'b0, '0);

        // ena pattern 1,0,0 with 12'hFFF
        step(1'b1, 1'b1, 12'hFFF);
        for (int i = 0; i < 3 * NB + 3; i++) step((i % 3) == 0, 1'b0, '0);

        // load mid-frame ignored
        step(1'b1, 1'b1, 12'h3C6);
        repeat (4) step(1'b1, 1'b0, '0);
        step(1'b1, 1'b1, 12'h001);
        repeat (NB) step(1'b1, 1'b1, 12'h001);
        repeat (3) step(1'b0, 1'b0, '0);

        // async reset after the 5th bit, then 12'h800
        step(1'b1, 1'b1, 12'h5A5);
        repeat (5) step(1'b1, 1'b0, '0);
        do_reset(2);
        step(1'b1, 1'b1, 12'h800);
        repeat (NB + 2) step(1'b1, 1'b0, '0);

        // odd-parity word
        step(1'b1, 1'b1, 12'hA5D);
        repeat (NB + 2) step(1'b1, 1'b0, '0);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 149) == 0) begin
                do_reset(int'($urandom_range(1, 3)));
            end else begin
                step($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0, WIDTH'($urandom));
            end
        end

        // drain the model
        budget = 0;
        while ((rem != 0 || dflag) && budget < 100) begin
            step(1'b1, 1'b0, '0);
            budget++;
        end
        step(1'b0, 1'b0, '0);
        stop = 1'b1;
        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL leftover_bits got=%0d exp=0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
